gemm_txn_sequencer: RTL and testbench

- Synthesizable ap_ctrl_hs launcher that sits directly upstream of the matrix_mult accelerator and of the dataflow monitor.
- Issues NUM_TRANS back-to-back start handshakes to the accelerator and measures per-transaction latency and pipelined-loop iteration count.
- Raises the `finish` level consumed by the monitor once all transactions complete, or once a watchdog timeout fires.

---
 rtl/gemm_txn_sequencer_if.sv | 22 ++
 rtl/gemm_txn_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_gemm_txn_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_txn_sequencer_if.sv
// ap_ctrl_hs handshake bundle between the transaction sequencer (master)
// and the matrix_mult accelerator plus its pipeline-fire tap (slave).
interface gemm_txn_sequencer_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic iter_fire;

    modport master (
        output ap_start,
        input  ap_ready,
        input  ap_done,
        input  iter_fire
    );

    modport slave (
        input  ap_start,
        output ap_ready,
        output ap_done,
        output iter_fire
    );
endinterface

// File: rtl/gemm_txn_sequencer.sv
// Launches NUM_TRANS back-to-back ap_ctrl_hs transactions, measures latency and
// pipelined-loop iterations per transaction, and raises finish for the monitor.
module gemm_txn_sequencer #(
    parameter int NUM_TRANS = 4,
    parameter int CNT_W     = 32,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_i,
    gemm_txn_sequencer_if.master ap,
    output logic                 finish_o,
    output logic                 timeout_err_o,
    output logic [CNT_W-1:0]     trans_count_o,
    output logic                 lat_valid_o,
    output logic [CNT_W-1:0]     last_latency_o,
    output logic [CNT_W-1:0]     last_iters_o,
    output logic [CNT_W-1:0]     min_latency_o,
    output logic [CNT_W-1:0]     max_latency_o
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAST_TRANS = CNT_W'(NUM_TRANS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP_WAIT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   trans_count_q, trans_count_d;
    logic               timeout_err_q, timeout_err_d;
    logic               lat_valid_q, lat_valid_d;
    logic [CNT_W-1:0]   last_latency_q, last_latency_d;
    logic [CNT_W-1:0]   last_iters_q, last_iters_d;
    logic [CNT_W-1:0]   min_latency_q, min_latency_d;
    logic [CNT_W-1:0]   max_latency_q, max_latency_d;
    logic               ap_start_q;
    logic               finish_q;

    logic [CNT_W-1:0]   lat_inc;
    logic [CNT_W-1:0]   iter_inc;
    logic               begin_run;
    logic               enter_start;
    logic               complete;

    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        iter_cnt_d     = iter_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        trans_count_d  = trans_count_q;
        timeout_err_d  = timeout_err_q;
        lat_valid_d    = 1'b0;
        last_latency_d = last_latency_q;
        last_iters_d   = last_iters_q;
        min_latency_d  = min_latency_q;
        max_latency_d  = max_latency_q;
        begin_run      = 1'b0;
        enter_start    = 1'b0;
        complete       = 1'b0;

        lat_inc  = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + CNT_W'(1);
        iter_inc = (ap.iter_fire && !(&iter_cnt_q)) ? iter_cnt_q + CNT_W'(1) : iter_cnt_q;

        // Done wins over the watchdog, so a transaction finishing on the last
        // permitted cycle is still reported rather than aborted.
        case (state_q)
            IDLE, DONE: begin
                if (run_i) begin
                    begin_run   = 1'b1;
                    enter_start = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (ap.ap_done) begin
                    complete = 1'b1;
                end else if (lat_cnt_q >= TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else if (ap.ap_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ap.ap_done) begin
                    complete = 1'b1;
                end else if (lat_cnt_q >= TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt_q == GAP_LAST) begin
                    enter_start = 1'b1;
                    state_d     = START;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == START || state_q == WAIT_DONE) begin
            lat_cnt_d  = lat_inc;
            iter_cnt_d = iter_inc;
        end

        if (complete) begin
            lat_valid_d    = 1'b1;
            last_latency_d = lat_cnt_q;
            last_iters_d   = iter_inc;
            trans_count_d  = trans_count_q + CNT_W'(1);
            if (lat_cnt_q < min_latency_q) begin
                min_latency_d = lat_cnt_q;
            end
            if (lat_cnt_q > max_latency_q) begin
                max_latency_d = lat_cnt_q;
            end
            if (trans_count_q == LAST_TRANS) begin
                state_d = DONE;
            end else if (GAP == 0) begin
                enter_start = 1'b1;
                state_d     = START;
            end else begin
                gap_cnt_d = '0;
                state_d   = GAP_WAIT;
            end
        end

        if (begin_run) begin
            trans_count_d = '0;
            timeout_err_d = 1'b0;
            min_latency_d = '1;
            max_latency_d = '0;
        end

        if (enter_start) begin
            lat_cnt_d  = '0;
            iter_cnt_d = '0;
        end
    end

    // ap_start and finish are registered from the next state so they track
    // the state register without combinational paths to the accelerator.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            lat_cnt_q      <= '0;
            iter_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            trans_count_q  <= '0;
            timeout_err_q  <= 1'b0;
            lat_valid_q    <= 1'b0;
            last_latency_q <= '0;
            last_iters_q   <= '0;
            min_latency_q  <= '1;
            max_latency_q  <= '0;
            ap_start_q     <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            iter_cnt_q     <= iter_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            trans_count_q  <= trans_count_d;
            timeout_err_q  <= timeout_err_d;
            lat_valid_q    <= lat_valid_d;
            last_latency_q <= last_latency_d;
            last_iters_q   <= last_iters_d;
            min_latency_q  <= min_latency_d;
            max_latency_q  <= max_latency_d;
            ap_start_q     <= (state_d == START);
            finish_q       <= (state_d == DONE);
        end
    end

    assign ap.ap_start     = ap_start_q;
    assign finish_o        = finish_q;
    assign timeout_err_o   = timeout_err_q;
    assign trans_count_o   = trans_count_q;
    assign lat_valid_o     = lat_valid_q;
    assign last_latency_o  = last_latency_q;
    assign last_iters_o    = last_iters_q;
    assign min_latency_o   = min_latency_q;
    assign max_latency_o   = max_latency_q;

endmodule

// File: tb/tb_gemm_txn_sequencer.sv
// Self-checking bench: plays the accelerator from a per-transaction plan
// (ready/done delays, fire masks) and checks outputs against that plan.
module tb_gemm_txn_sequencer;

    localparam int NT   = 4;
    localparam int GAPC = 2;
    localparam int TMO  = 50;
    localparam int W    = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         runPulse;
    logic         finish;
    logic         timeoutErr;
    logic         latValid;
    logic [W-1:0] transCount;
    logic [W-1:0] lastLatency;
    logic [W-1:0] lastIters;
    logic [W-1:0] minLatency;
    logic [W-1:0] maxLatency;

    int checks = 0;
    int errors = 0;

    int          readyDly [NT];
    int          doneDly  [NT];
    logic [63:0] fireMask [NT];
    int          resetTxn = -1;
    int          resetCyc = -1;

    gemm_txn_sequencer_if apIf ();

    gemm_txn_sequencer #(
        .NUM_TRANS(NT),
        .CNT_W    (W),
        .GAP      (GAPC),
        .TIMEOUT  (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run_i         (runPulse),
        .ap            (apIf),
        .finish_o      (finish),
        .timeout_err_o (timeoutErr),
        .trans_count_o (transCount),
        .lat_valid_o   (latValid),
        .last_latency_o(lastLatency),
        .last_iters_o  (lastIters),
        .min_latency_o (minLatency),
        .max_latency_o (maxLatency)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int countFires(input logic [63:0] m, input int last);
        int n = 0;
        for (int j = 0; j <= last; j++) n += int'(m[j]);
        return n;
    endfunction

    task automatic clearInputs();
        apIf.ap_ready  = 1'b0;
        apIf.ap_done   = 1'b0;
        apIf.iter_fire = 1'b0;
        runPulse       = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ap_start"},     64'(apIf.ap_start), 64'd0);
        checkOutput({tag, ".finish"},       64'(finish),        64'd0);
        checkOutput({tag, ".timeout_err"},  64'(timeoutErr),    64'd0);
        checkOutput({tag, ".trans_count"},  64'(transCount),    64'd0);
        checkOutput({tag, ".lat_valid"},    64'(latValid),      64'd0);
        checkOutput({tag, ".last_latency"}, 64'(lastLatency),   64'd0);
        checkOutput({tag, ".last_iters"},   64'(lastIters),     64'd0);
        checkOutput({tag, ".min_latency"},  64'(minLatency),    64'hFFFF_FFFF);
        checkOutput({tag, ".max_latency"},  64'(maxLatency),    64'd0);
    endtask

    task automatic checkHold(input bit expFinish, input bit expTimeout);
        repeat (3) begin
            @(negedge clock);
            checkOutput("hold.finish",      64'(finish),        64'(expFinish));
            checkOutput("hold.timeout_err", 64'(timeoutErr),    64'(expTimeout));
            checkOutput("hold.ap_start",    64'(apIf.ap_start), 64'd0);
            checkOutput("hold.lat_valid",   64'(latValid),      64'd0);
        end
    endtask

    // Plays one run of the current plan; called at a negedge with the DUT idle or done.
    task automatic applyStimulus();
        logic [W-1:0] expMin;
        logic [W-1:0] expMax;
        int  eff;
        int  d;
        int  iters;
        bit  doneSeen;
        expMin = '1;
        expMax = '0;
        runPulse = 1'b1;
        @(negedge clock);
        runPulse = 1'b0;
        for (int i = 0; i < NT; i++) begin
            d = doneDly[i];
            eff = (d >= 0 && d < readyDly[i]) ? d : readyDly[i];
            doneSeen = 1'b0;
            for (int k = 0; k <= TMO && !doneSeen; k++) begin
                if (k == TMO) begin
                    checkOutput("abort.timeout_err", 64'(timeoutErr),    64'd1);
                    checkOutput("abort.finish",      64'(finish),        64'd1);
                    checkOutput("abort.ap_start",    64'(apIf.ap_start), 64'd0);
                    checkOutput("abort.trans_count", 64'(transCount),    64'(i));
                    checkOutput("abort.lat_valid",   64'(latValid),      64'd0);
                    checkOutput("abort.min_latency", 64'(minLatency),    64'(expMin));
                    checkOutput("abort.max_latency", 64'(maxLatency),    64'(expMax));
                    clearInputs();
                    return;
                end
                checkOutput("txn.ap_start",  64'(apIf.ap_start), 64'(k <= eff));
                checkOutput("txn.lat_valid", 64'(latValid),      64'd0);
                checkOutput("txn.finish",    64'(finish),        64'd0);
                if (i == 0 && k == 0) begin
                    checkOutput("runstart.trans_count", 64'(transCount), 64'd0);
                    checkOutput("runstart.timeout_err", 64'(timeoutErr), 64'd0);
                    checkOutput("runstart.min_latency", 64'(minLatency), 64'hFFFF_FFFF);
                    checkOutput("runstart.max_latency", 64'(maxLatency), 64'd0);
                end
                if (i == resetTxn && k == resetCyc) begin
                    clearInputs();
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    checkResetValues("midreset");
                    return;
                end
                apIf.ap_ready  = (k == readyDly[i]) || (k > readyDly[i] && $urandom_range(0, 3) == 0);
                apIf.ap_done   = (k == d);
                apIf.iter_fire = fireMask[i][k];
                runPulse       = (k > 0) && ((k == eff + 1) || $urandom_range(0, 7) == 0);
                @(negedge clock);
                if (k == d) doneSeen = 1'b1;
            end
            iters = countFires(fireMask[i], d);
            if (W'(d) < expMin) expMin = W'(d);
            if (W'(d) > expMax) expMax = W'(d);
            checkOutput("done.lat_valid",    64'(latValid),      64'd1);
            checkOutput("done.last_latency", 64'(lastLatency),   64'(d));
            checkOutput("done.last_iters",   64'(lastIters),     64'(iters));
            checkOutput("done.trans_count",  64'(transCount),    64'(i + 1));
            checkOutput("done.min_latency",  64'(minLatency),    64'(expMin));
            checkOutput("done.max_latency",  64'(maxLatency),    64'(expMax));
            checkOutput("done.ap_start",     64'(apIf.ap_start), 64'd0);
            checkOutput("done.finish",       64'(finish),        64'(i == NT - 1));
            checkOutput("done.timeout_err",  64'(timeoutErr),    64'd0);
            clearInputs();
            if (i < NT - 1) begin
                for (int g = 0; g < GAPC; g++) begin
                    apIf.iter_fire = 1'($urandom_range(0, 1));
                    runPulse       = ($urandom_range(0, 3) == 0);
                    @(negedge clock);
                    if (g < GAPC - 1) begin
                        checkOutput("gap.ap_start",  64'(apIf.ap_start), 64'd0);
                        checkOutput("gap.lat_valid", 64'(latValid),      64'd0);
                    end
                end
                clearInputs();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        repeat (3) @(negedge clock);
        checkResetValues("por");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkResetValues("idle");

        // Fixed latency 10, ready immediately.
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 0;
            doneDly[i]  = 10;
            fireMask[i] = {$urandom, $urandom};
        end
        applyStimulus();
        checkHold(1'b1, 1'b0);

        // Ready and done together one cycle after start; launched from DONE.
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 1;
            doneDly[i]  = 1;
            fireMask[i] = {$urandom, $urandom};
        end
        applyStimulus();
        checkHold(1'b1, 1'b0);

        // Latencies 7, 12, 9, 15 with 8-fire bursts ending on the done cycle.
        doneDly[0] = 7;
        doneDly[1] = 12;
        doneDly[2] = 9;
        doneDly[3] = 15;
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 2;
            fireMask[i] = 64'hFF << (doneDly[i] - 7);
        end
        applyStimulus();
        checkHold(1'b1, 1'b0);

        // Watchdog on the first transaction.
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 0;
            doneDly[i]  = -1;
            fireMask[i] = {$urandom, $urandom};
        end
        applyStimulus();
        checkHold(1'b1, 1'b1);

        // Watchdog on the third transaction, accelerator never accepts.
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 3;
            doneDly[i]  = 5 + i;
            fireMask[i] = {$urandom, $urandom};
        end
        readyDly[2] = 100;
        doneDly[2]  = -1;
        applyStimulus();
        checkHold(1'b1, 1'b1);

        // Reset in the middle of WAIT_DONE of the third transaction.
        for (int i = 0; i < NT; i++) begin
            readyDly[i] = 1;
            doneDly[i]  = 20;
            fireMask[i] = {$urandom, $urandom};
        end
        resetTxn = 2;
        resetCyc = 5;
        applyStimulus();
        resetTxn = -1;
        resetCyc = -1;
        checkHold(1'b0, 1'b0);
        applyStimulus();
        checkHold(1'b1, 1'b0);

        // Randomized runs, occasionally with a transaction that never completes.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NT; i++) begin
                readyDly[i] = $urandom_range(0, 6);
                doneDly[i]  = $urandom_range(0, 30);
                fireMask[i] = {$urandom, $urandom};
            end
            if ($urandom_range(0, 3) == 0) doneDly[$urandom_range(0, NT - 1)] = -1;
            applyStimulus();
            @(negedge clock);
            checkOutput("rand.finish", 64'(finish), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
